// File: rtl/mem_port_arbiter.sv
// Single-port memory scheduler: shares one memory port between instruction fetch
// and load/store, with wait-state tolerance and a sticky bus-timeout flag.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic [DATA_WIDTH-1:0]   fetch_rdata,
  output logic                    fetch_done,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [DATA_WIDTH/8-1:0] data_be,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic                    data_done,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    blocked,
  output logic                    bus_error,
  output logic [1:0]              dbg_state
);

  // Handshake: a requester holds its req level (payload may change freely) until
  // its one-cycle done pulse and drops it on the edge ending that cycle. The memory
  // side sees mem_valid high with mem_* stable until the cycle it raises mem_ready.
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                busy;
  logic                timeout;
  logic                sel_data_q;
  logic                we_q;
  logic [BE_W-1:0]     be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] fetch_rdata_q;
  logic [DATA_WIDTH-1:0] data_rdata_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                bus_error_q;

  assign busy = (state == BUSY_F) || (state == BUSY_D);

  // The cycle that would bring the wait count up to MAX_WAIT is the last BUSY cycle.
  always_comb begin
    timeout = 1'b0;
    if (MAX_WAIT != 0) begin
      timeout = busy && !mem_ready && (wait_cnt == CNT_W'(MAX_WAIT - 1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (data_req) begin
          state_nxt = BUSY_D;
        end else if (fetch_req) begin
          state_nxt = BUSY_F;
        end
      end
      BUSY_F, BUSY_D: begin
        if (mem_ready || timeout) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, wait counting and read-data/error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_data_q    <= 1'b0;
      we_q          <= 1'b0;
      be_q          <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wait_cnt      <= '0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      bus_error_q   <= 1'b0;
    end else begin
      if (state == IDLE && data_req) begin
        sel_data_q <= 1'b1;
        we_q       <= data_we;
        be_q       <= data_be;
        addr_q     <= data_addr;
        wdata_q    <= data_wdata;
        wait_cnt   <= '0;
      end else if (state == IDLE && fetch_req) begin
        sel_data_q <= 1'b0;
        we_q       <= 1'b0;
        be_q       <= '1;
        addr_q     <= fetch_addr;
        wdata_q    <= '0;
        wait_cnt   <= '0;
      end else if (busy && !mem_ready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == BUSY_F) begin
        if (mem_ready) begin
          fetch_rdata_q <= mem_rdata;
        end else if (timeout) begin
          fetch_rdata_q <= '0;
        end
      end

      // Stores complete without disturbing the last load result.
      if (state == BUSY_D) begin
        if (mem_ready) begin
          if (!we_q) begin
            data_rdata_q <= mem_rdata;
          end
        end else if (timeout) begin
          data_rdata_q <= '0;
        end
      end

      if (timeout) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_valid   = busy;
    blocked     = busy;
    mem_we      = busy && we_q;
    mem_be      = be_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    fetch_done  = (state == RESP) && !sel_data_q;
    data_done   = (state == RESP) && sel_data_q;
    fetch_rdata = fetch_rdata_q;
    data_rdata  = data_rdata_q;
    bus_error   = bus_error_q;
    dbg_state   = state;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port memory scheduler for the multi-cycle RISC-V core.
- Shares one memory port between the instruction-fetch requester (fetch stage) and the load/store requester (memory stage).
- Drives the stage counter's `blocked` input while an access is outstanding.
- Provides wait-state tolerance and a bus-timeout error.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of data buses; byte enables are DATA_WIDTH/8 bits
MAX_WAIT, 15, number of BUSY cycles without mem_ready before abort; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
fetch_req  in  1  fetch request level, held until fetch_done
fetch_addr  in  ADDR_WIDTH  fetch address
fetch_rdata  out  DATA_WIDTH  fetched word, valid while fetch_done=1, held afterwards
fetch_done  out  1  one-cycle completion pulse
data_req  in  1  load/store request level, held until data_done
data_we  in  1  1=store, 0=load
data_be  in  DATA_WIDTH/8  store byte enables
data_addr  in  ADDR_WIDTH  load/store address
data_wdata  in  DATA_WIDTH  store data
data_rdata  out  DATA_WIDTH  load result, valid while data_done=1, held afterwards
data_done  out  1  one-cycle completion pulse
mem_valid  out  1  memory access in progress
mem_we  out  1  memory write strobe
mem_be  out  DATA_WIDTH/8  memory byte enables
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, sampled when mem_ready=1
mem_ready  in  1  memory completes the access this cycle
blocked  out  1  high while an access is in BUSY_F or BUSY_D
bus_error  out  1  sticky timeout flag

Behaviour:
- Reset:
  - rst=0 forces state IDLE asynchronously.
  - All outputs are 0 while rst=0, including the rdata registers, wait counter and bus_error.
- FSM states: IDLE, BUSY_F, BUSY_D, RESP.
- IDLE:
  - If data_req=1, go to BUSY_D.
  - Else if fetch_req=1, go to BUSY_F.
  - Else stay in IDLE.
  - Data always wins simultaneous requests; the memory stage is the older instruction.
- Grant capture:
  - On the IDLE->BUSY edge, addr, we, be and wdata are registered into mem_* outputs.
  - Requester input changes after grant are ignored.
  - Fetch: mem_we=0, mem_be=all ones, mem_wdata=0.
- BUSY_x:
  - mem_valid=1, blocked=1, mem_* outputs held stable.
  - Wait counter increments each cycle with mem_ready=0.
  - mem_ready=1: capture mem_rdata into x_rdata (loads and fetches only; stores leave data_rdata unchanged), go to RESP.
  - Timeout: when MAX_WAIT!=0 and the counter reaches MAX_WAIT, go to RESP, set x_rdata=0, set bus_error=1.
- RESP:
  - Exactly one cycle.
  - mem_valid=0, mem_we=0, blocked=0.
  - Done pulse for the served requester; always returns to IDLE.
  - Requests are not sampled in RESP. Requesters drop req on the edge that ends RESP, so a completed request is never re-granted.
- Latency:
  - Request seen in IDLE in cycle 0 -> mem_valid from cycle 1.
  - mem_ready in cycle 1+N -> done in cycle 2+N.
  - Back-to-back accesses take 3 cycles each at zero wait states.
- Fairness: a fetch still pending after a data access is granted in the IDLE cycle following RESP, unless data_req is high again.
- bus_error is sticky; it clears only on reset.
- Wait counter clears on every grant.
- Reset mid-BUSY: mem_valid drops immediately (asynchronous), no done pulse, rdata registers cleared.
- mem_ready while not BUSY is ignored.

Test Plan:
- Reset: rst=0 for 2 cycles with random inputs -> all outputs 0; state IDLE after release.
- Zero-wait fetch:
  - Stimulus: fetch_req=1, fetch_addr=0x00000010, mem_ready tied 1, mem_rdata=0x00500093.
  - Response: cycle1 mem_valid=1, mem_addr=0x10, mem_we=0, mem_be=0xF, blocked=1; cycle2 fetch_done=1, fetch_rdata=0x00500093, blocked=0.
- Simultaneous requests:
  - Stimulus: fetch_req and data_req both high; store with data_addr=0x100, data_wdata=0xDEADBEEF, data_be=0x3.
  - Response: data served first with mem_we=1, mem_be=0x3; data_done; fetch granted in the next IDLE cycle; fetch_done 3 cycles after data_done.
- Wait states:
  - Stimulus: load from 0x200, mem_ready asserted after 3 low cycles, mem_rdata=0x12345678.
  - Response: mem_valid and blocked high 4 cycles with mem_addr stable; data_done one cycle after ready; data_rdata=0x12345678.
- Timeout:
  - Stimulus: MAX_WAIT=8, mem_ready never asserted.
  - Response: after 8 BUSY cycles, fetch_done=1 with fetch_rdata=0, bus_error=1; bus_error stays 1 over later good accesses until reset.
- Reset mid-access:
  - Stimulus: rst=0 during the 2nd wait cycle.
  - Response: mem_valid=0 asynchronously, no done pulse; after rst=1, a new fetch completes normally.
